// File: rtl/glyph_sequencer.sv
// ============================================================================
//  Module   : glyph_sequencer
//  Purpose  : Glyph index sequencer for the 8x8 dot-matrix scan driver
//             (play/pause, direction, single-step, dwell, blanked wrap gap).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module glyph_sequencer #(
    parameter int NUM_FRAMES = 5,
    parameter int DWELL      = 1,
    parameter int GAP_TICKS  = 2
) (
    input  logic       clk_2,
    input  logic       rst,
    input  logic       play,
    input  logic       dir,
    input  logic       step_fwd,
    input  logic       step_back,
    output logic [3:0] code,
    output logic       blank,
    output logic       frame_start,
    output logic       wrap
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_show    = 2'd1;
    localparam logic [1:0] c_st_gap     = 2'd2;
    localparam logic [3:0] c_last_code  = 4'(NUM_FRAMES - 1);
    localparam logic [7:0] c_dwell_last = 8'(DWELL - 1);
    localparam logic [7:0] c_gap_last   = 8'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit         c_has_gap    = (GAP_TICKS > 0);

    logic [1:0] r_state;
    logic [7:0] r_dwell_cnt;
    logic [7:0] r_gap_cnt;
    logic [3:0] r_pending;
    logic       r_fwd_prev;
    logic       r_back_prev;

    logic       w_fwd_edge;
    logic       w_back_edge;
    logic       w_single_step;
    logic       w_go_back;
    logic       w_at_wrap;
    logic [3:0] w_next_code;

    assign w_fwd_edge    = step_fwd & ~r_fwd_prev;
    assign w_back_edge   = step_back & ~r_back_prev;
    assign w_single_step = w_fwd_edge ^ w_back_edge;

    // While playing the direction comes from dir; while paused from which step fired.
    assign w_go_back = play ? dir : w_back_edge;
    assign w_at_wrap = w_go_back ? (code == 4'd0) : (code == c_last_code);

    always_comb begin
        w_next_code = code;
        if (w_go_back) begin
            w_next_code = w_at_wrap ? c_last_code : code - 4'd1;
        end else begin
            w_next_code = w_at_wrap ? 4'd0 : code + 4'd1;
        end
    end

    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_dwell_cnt <= 8'd0;
            r_gap_cnt   <= 8'd0;
            r_pending   <= 4'd0;
            r_fwd_prev  <= 1'b0;
            r_back_prev <= 1'b0;
            code        <= 4'd0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            r_fwd_prev  <= step_fwd;
            r_back_prev <= step_back;
            frame_start <= 1'b0;
            wrap        <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_state     <= c_st_show;
                    blank       <= 1'b0;
                    frame_start <= 1'b1;
                end
                c_st_show: begin
                    if (play) begin
                        if (r_dwell_cnt == c_dwell_last) begin
                            r_dwell_cnt <= 8'd0;
                            wrap        <= w_at_wrap;
                            // A wrap with a gap holds the old code under blanking.
                            if (w_at_wrap && c_has_gap) begin
                                r_state   <= c_st_gap;
                                blank     <= 1'b1;
                                r_gap_cnt <= 8'd0;
                                r_pending <= w_next_code;
                            end else begin
                                code        <= w_next_code;
                                frame_start <= 1'b1;
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + 8'd1;
                        end
                    end else if (w_single_step) begin
                        code        <= w_next_code;
                        r_dwell_cnt <= 8'd0;
                        frame_start <= 1'b1;
                        wrap        <= w_at_wrap;
                    end
                end
                c_st_gap: begin
                    if ((play && r_gap_cnt == c_gap_last) || (!play && w_single_step)) begin
                        r_state     <= c_st_show;
                        code        <= r_pending;
                        blank       <= 1'b0;
                        frame_start <= 1'b1;
                        r_dwell_cnt <= 8'd0;
                    end else if (play) begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_glyph_sequencer.sv
// ============================================================================
//  Module   : tb_glyph_sequencer
//  Purpose  : Scoreboard bench for glyph_sequencer (default and DWELL=3/no-gap builds).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_glyph_sequencer;

    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // Instance A: defaults. Instance B: DWELL=3, GAP_TICKS=0.
    logic       rst_a, play_a, dir_a, sf_a, sb_a;
    logic [3:0] code_a;
    logic       blank_a, fs_a, wrap_a;
    logic       rst_b, play_b, dir_b, sf_b, sb_b;
    logic [3:0] code_b;
    logic       blank_b, fs_b, wrap_b;

    glyph_sequencer dut_a (
        .clk_2(clk_2), .rst(rst_a), .play(play_a), .dir(dir_a),
        .step_fwd(sf_a), .step_back(sb_a),
        .code(code_a), .blank(blank_a), .frame_start(fs_a), .wrap(wrap_a)
    );

    glyph_sequencer #(.NUM_FRAMES(5), .DWELL(3), .GAP_TICKS(0)) dut_b (
        .clk_2(clk_2), .rst(rst_b), .play(play_b), .dir(dir_b),
        .step_fwd(sf_b), .step_back(sb_b),
        .code(code_b), .blank(blank_b), .frame_start(fs_b), .wrap(wrap_b)
    );

    logic [6:0] obs_a, obs_b;
    assign obs_a = {code_a, blank_a, fs_a, wrap_a};
    assign obs_b = {code_b, blank_b, fs_b, wrap_b};

    logic [6:0] exp_q[$];
    logic [6:0] exp_v;
    int n_checks = 0;
    int n_errors = 0;

    // Expected-tuple builder: {code, blank, frame_start, wrap}
    function automatic logic [6:0] e(input int c, input bit b, input bit f, input bit w);
        return {4'(c), b, f, w};
    endfunction

    task automatic test_reset();
        @(posedge clk_2); #1;
        exp_q.push_back(e(0, 1, 0, 0));
        exp_q.push_back(e(0, 1, 0, 0));
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs_a !== exp_v) begin
            n_errors++;
            $display("FAIL reset_a: got %b want %b (code,blank,fs,wrap)", obs_a, exp_v);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs_b !== exp_v) begin
            n_errors++;
            $display("FAIL reset_b: got %b want %b (code,blank,fs,wrap)", obs_b, exp_v);
        end
    endtask

    task automatic test_play_forward();
        exp_q.push_back(e(0, 0, 1, 0));
        for (int c = 1; c <= 4; c++) exp_q.push_back(e(c, 0, 1, 0));
        exp_q.push_back(e(4, 1, 0, 1));
        exp_q.push_back(e(4, 1, 0, 0));
        exp_q.push_back(e(0, 0, 1, 0));
        exp_q.push_back(e(1, 0, 1, 0));
        rst_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_a !== exp_v) begin
                n_errors++;
                $display("FAIL play_fwd[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_a, exp_v);
            end
        end
    endtask

    task automatic test_gap_step();
        exp_q.push_back(e(2, 0, 1, 0));
        exp_q.push_back(e(3, 0, 1, 0));
        exp_q.push_back(e(4, 0, 1, 0));
        exp_q.push_back(e(4, 1, 0, 1));
        for (int i = 0; i < 3; i++) exp_q.push_back(e(4, 1, 0, 0));
        exp_q.push_back(e(0, 0, 1, 0));
        exp_q.push_back(e(0, 0, 0, 0));
        for (int i = 0; i < 9; i++) begin
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_a !== exp_v) begin
                n_errors++;
                $display("FAIL gap_step[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_a, exp_v);
            end
            if (i == 3) play_a = 1'b0;
            if (i == 6) sb_a = 1'b1;
            if (i == 7) sb_a = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        play_a = 1'b1;
        for (int c = 1; c <= 3; c++) exp_q.push_back(e(c, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_a !== exp_v) begin
                n_errors++;
                $display("FAIL pre_rst[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_a, exp_v);
            end
        end
        #2 rst_a = 1'b1;
        #1;
        exp_q.push_back(e(0, 1, 0, 0));
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs_a !== exp_v) begin
            n_errors++;
            $display("FAIL async_rst: got %b want %b (code,blank,fs,wrap)", obs_a, exp_v);
        end
        @(posedge clk_2); #1;
        exp_q.push_back(e(0, 1, 0, 0));
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs_a !== exp_v) begin
            n_errors++;
            $display("FAIL rst_held: got %b want %b (code,blank,fs,wrap)", obs_a, exp_v);
        end
        rst_a = 1'b0;
        exp_q.push_back(e(0, 0, 1, 0));
        for (int c = 1; c <= 4; c++) exp_q.push_back(e(c, 0, 1, 0));
        exp_q.push_back(e(4, 1, 0, 1));
        exp_q.push_back(e(4, 1, 0, 0));
        exp_q.push_back(e(0, 0, 1, 0));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_a !== exp_v) begin
                n_errors++;
                $display("FAIL restart[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_a, exp_v);
            end
        end
    endtask

    task automatic test_reverse_dwell();
        exp_q.push_back(e(0, 0, 1, 0));
        exp_q.push_back(e(0, 0, 0, 0));
        exp_q.push_back(e(0, 0, 0, 0));
        for (int c = 4; c >= 0; c--) begin
            exp_q.push_back(e(c, 0, 1, (c == 4)));
            exp_q.push_back(e(c, 0, 0, 0));
            exp_q.push_back(e(c, 0, 0, 0));
        end
        rst_b  = 1'b0;
        play_b = 1'b1;
        dir_b  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_b !== exp_v) begin
                n_errors++;
                $display("FAIL rev_dwell[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_b, exp_v);
            end
        end
    endtask

    task automatic test_pause();
        dir_b = 1'b0;
        exp_q.push_back(e(1, 0, 1, 0));
        exp_q.push_back(e(1, 0, 0, 0));
        exp_q.push_back(e(1, 0, 0, 0));
        exp_q.push_back(e(2, 0, 1, 0));
        for (int i = 0; i < 12; i++) exp_q.push_back(e(2, 0, 0, 0));
        exp_q.push_back(e(3, 0, 1, 0));
        for (int i = 0; i < 17; i++) begin
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_b !== exp_v) begin
                n_errors++;
                $display("FAIL pause[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_b, exp_v);
            end
            if (i == 4)  play_b = 1'b0;
            if (i == 14) play_b = 1'b1;
        end
    endtask

    task automatic test_step();
        bit sf_seq[11] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0};
        bit sb_seq[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit pl_seq[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        exp_q.push_back(e(4, 0, 1, 0));
        exp_q.push_back(e(4, 0, 0, 0));
        exp_q.push_back(e(0, 0, 1, 1));
        for (int i = 0; i < 6; i++) exp_q.push_back(e(0, 0, 0, 0));
        exp_q.push_back(e(4, 0, 1, 1));
        exp_q.push_back(e(4, 0, 0, 0));
        for (int i = 0; i < 11; i++) begin
            sf_b   = sf_seq[i];
            sb_b   = sb_seq[i];
            play_b = pl_seq[i];
            @(posedge clk_2); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_b !== exp_v) begin
                n_errors++;
                $display("FAIL step[%0d]: got %b want %b (code,blank,fs,wrap)", i, obs_b, exp_v);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; play_a = 1'b1; dir_a = 1'b0; sf_a = 1'b0; sb_a = 1'b0;
        rst_b = 1'b1; play_b = 1'b0; dir_b = 1'b0; sf_b = 1'b0; sb_b = 1'b0;
        test_reset();
        test_play_forward();
        test_gap_step();
        test_reset_mid();
        test_reverse_dwell();
        test_pause();
        test_step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
